skid_fifo: RTL

- Parametrised successor to the single-slot skid buffer: ready/valid elastic buffer holding up to DEPTH words.
- o_data, o_output_valid and o_input_ready are all driven directly from flops, so no combinational path runs between the two interfaces.
- Used to break timing on long ready/valid channels and to absorb burst backpressure between pipeline stages.

---
 rtl/skid_fifo_if.sv | 56 +++++
 rtl/skid_fifo.sv | 119 +++++++++++
 2 files changed

// File: rtl/skid_fifo_if.sv
// Ready/valid handshake bundle for skid_fifo. The almost-full/empty flags exist only when
// SKID_FIFO_ALMOST_FLAGS_EN is defined.
interface skid_fifo_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned COUNT_WIDTH = $clog2(DEPTH + 1)
);
  logic                   i_clear;
  logic [DATA_WIDTH-1:0]  i_data;
  logic                   i_input_valid;
  logic                   o_input_ready;
  logic [DATA_WIDTH-1:0]  o_data;
  logic                   o_output_valid;
  logic                   i_output_ready;
  logic                   o_accept;
  logic                   o_transmit;
  logic [COUNT_WIDTH-1:0] o_count;
`ifdef SKID_FIFO_ALMOST_FLAGS_EN
  logic                   o_almost_full;
  logic                   o_almost_empty;
`endif

  modport master (
`ifdef SKID_FIFO_ALMOST_FLAGS_EN
    input  o_almost_full,
    input  o_almost_empty,
`endif
    output i_clear,
    output i_data,
    output i_input_valid,
    output i_output_ready,
    input  o_input_ready,
    input  o_data,
    input  o_output_valid,
    input  o_accept,
    input  o_transmit,
    input  o_count
  );

  modport slave (
`ifdef SKID_FIFO_ALMOST_FLAGS_EN
    output o_almost_full,
    output o_almost_empty,
`endif
    input  i_clear,
    input  i_data,
    input  i_input_valid,
    input  i_output_ready,
    output o_input_ready,
    output o_data,
    output o_output_valid,
    output o_accept,
    output o_transmit,
    output o_count
  );
endinterface

// File: rtl/skid_fifo.sv
// Elastic ready/valid FIFO: registered head word plus a (DEPTH-1)-entry circular buffer.
// Optional almost-full/almost-empty flags are enabled with SKID_FIFO_ALMOST_FLAGS_EN.
module skid_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned COUNT_WIDTH = $clog2(DEPTH + 1)
`ifdef SKID_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1
`endif
) (
  input logic        i_clock,
  input logic        i_aresetn,
  skid_fifo_if.slave bus
);
  localparam int unsigned BufDepth = DEPTH - 1;
  localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  typedef logic [PtrWidth-1:0] ptr_t;
  localparam ptr_t PtrLast = ptr_t'(BufDepth - 1);

  logic [DATA_WIDTH-1:0]  mem_q [BufDepth];
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  ptr_t                   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   valid_q, ready_q;
  logic                   accept, transmit, buf_empty, mem_we;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == PtrLast) ? '0 : p + ptr_t'(1);
  endfunction

  assign accept    = bus.i_input_valid && ready_q;
  assign transmit  = valid_q && bus.i_output_ready;
  // Buffer holds count-1 words whenever the head is occupied.
  assign buf_empty = (count_q < COUNT_WIDTH'(2));
  assign count_d   = count_q + COUNT_WIDTH'(accept) - COUNT_WIDTH'(transmit);

  always_comb begin
    head_d   = head_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_we   = 1'b0;
    if (accept && (!valid_q || (transmit && buf_empty))) begin
      head_d = bus.i_data;
    end else begin
      if (transmit && !buf_empty) begin
        head_d   = mem_q[rd_ptr_q];
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (accept) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      head_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else if (bus.i_clear) begin
      head_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      ready_q  <= (count_d != COUNT_WIDTH'(DEPTH));
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int i = 0; i < int'(BufDepth); i++) mem_q[i] <= '0;
    end else if (bus.i_clear) begin
      for (int i = 0; i < int'(BufDepth); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

`ifdef SKID_FIFO_ALMOST_FLAGS_EN
  logic afull_q, aempty_q;

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else if (bus.i_clear) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= (count_d >= COUNT_WIDTH'(AFULL_LEVEL));
      aempty_q <= (count_d <= COUNT_WIDTH'(AEMPTY_LEVEL));
    end
  end

  assign bus.o_almost_full  = afull_q;
  assign bus.o_almost_empty = aempty_q;
`endif

  assign bus.o_data         = head_q;
  assign bus.o_output_valid = valid_q;
  assign bus.o_input_ready  = ready_q;
  assign bus.o_count        = count_q;
  assign bus.o_accept       = accept;
  assign bus.o_transmit     = transmit;
endmodule
